// File: rtl/shift_pkg.sv
// Shared constants and types for the shifter-path sequencer and its decoder.
package shift_pkg;

    // Shift-class opcodes presented by the main control unit
    localparam logic [2:0] OP_SLL  = 3'b000;
    localparam logic [2:0] OP_SRL  = 3'b001;
    localparam logic [2:0] OP_SRA  = 3'b010;
    localparam logic [2:0] OP_SLLV = 3'b011;
    localparam logic [2:0] OP_SRLV = 3'b100;
    localparam logic [2:0] OP_SRAV = 3'b101;
    localparam logic [2:0] OP_LUI  = 3'b110;
    localparam logic [2:0] OP_ILL  = 3'b111;

    // RegDesloc commands
    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_LEFT = 3'b010;
    localparam logic [2:0] SH_RLOG = 3'b011;
    localparam logic [2:0] SH_RARI = 3'b100;

    // ShifterMux selects: where the data word and shift amount come from
    localparam logic [1:0] SMUX_REGVAR = 2'b00;  // N = B[4:0], data = A
    localparam logic [1:0] SMUX_SHAMT  = 2'b01;  // N = imm[4:0], data = B
    localparam logic [1:0] SMUX_LUI    = 2'b10;  // N = 16, data = zext(imm)

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/shift_sequencer_decode.sv
// Opcode decoder for the shifter path: operand/amount select, shift direction
// and legality. Purely combinational so the main control unit can reuse it.
module shift_op_decode
    import shift_pkg::*;
(
    input  logic [2:0] op,
    output logic [1:0] sel,
    output logic [2:0] dir,
    output logic       legal
);

    // Map each opcode to its mux source and RegDesloc shift command
    always_comb begin
        sel   = SMUX_REGVAR;
        dir   = SH_NOP;
        legal = 1'b1;
        case (op)
            OP_SLL: begin
                sel = SMUX_SHAMT;
                dir = SH_LEFT;
            end
            OP_SRL: begin
                sel = SMUX_SHAMT;
                dir = SH_RLOG;
            end
            OP_SRA: begin
                sel = SMUX_SHAMT;
                dir = SH_RARI;
            end
            OP_SLLV: begin
                sel = SMUX_REGVAR;
                dir = SH_LEFT;
            end
            OP_SRLV: begin
                sel = SMUX_REGVAR;
                dir = SH_RLOG;
            end
            OP_SRAV: begin
                sel = SMUX_REGVAR;
                dir = SH_RARI;
            end
            OP_LUI: begin
                sel = SMUX_LUI;
                dir = SH_LEFT;
            end
            OP_ILL: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle sequencer for the shifter datapath: load -> shift -> done.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | waiting for start; outputs quiet
//   LOAD     | RegDesloc loads the selected data word
//   SHIFT    | RegDesloc shifts by the selected amount in op_q direction
//   DONE     | result valid on Saida; done/reg_wr pulse; may accept next op
//   ERR      | illegal opcode seen; error pulse, start ignored
//
// Every output is a flop loaded from the next-state decode, so outputs line
// up with the state register and no input reaches an output combinationally.
module shift_sequencer
    import shift_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] op,
    output logic [1:0] ShifterMux,
    output logic [2:0] Shift,
    output logic       busy,
    output logic       done,
    output logic       reg_wr,
    output logic       error
);

    state_t     state;
    state_t     state_nxt;
    logic [2:0] op_q;
    logic [2:0] op_nxt;

    logic       accept;
    logic [2:0] op_cand;
    logic [1:0] cand_sel;
    logic [2:0] cand_dir;
    logic       cand_legal;

    logic [1:0] smux_nxt;
    logic [2:0] shift_nxt;
    logic       busy_nxt;
    logic       done_nxt;
    logic       reg_wr_nxt;
    logic       error_nxt;

    // Start is only honoured in IDLE or DONE; decode the incoming op when it
    // is accepted, otherwise keep decoding the latched op. One decoder covers
    // both the legality test and the output mapping for the next state.
    always_comb begin
        accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
        op_cand = accept ? op : op_q;
    end

    shift_op_decode u_decode (
        .op    (op_cand),
        .sel   (cand_sel),
        .dir   (cand_dir),
        .legal (cand_legal)
    );

    // Next-state and opcode-latch logic
    always_comb begin
        state_nxt = state;
        op_nxt    = op_q;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    if (cand_legal) begin
                        state_nxt = ST_LOAD;
                        op_nxt    = op;
                    end else begin
                        state_nxt = ST_ERR;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: state_nxt = ST_DONE;
            ST_ERR:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Moore output decode of the state being entered; op_cand equals op_nxt
    // whenever the next state is LOAD, SHIFT or DONE.
    always_comb begin
        smux_nxt   = SMUX_REGVAR;
        shift_nxt  = SH_NOP;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        reg_wr_nxt = 1'b0;
        error_nxt  = 1'b0;
        case (state_nxt)
            ST_LOAD: begin
                smux_nxt  = cand_sel;
                shift_nxt = SH_LOAD;
                busy_nxt  = 1'b1;
            end
            ST_SHIFT: begin
                smux_nxt  = cand_sel;
                shift_nxt = cand_dir;
                busy_nxt  = 1'b1;
            end
            ST_DONE: begin
                smux_nxt   = cand_sel;
                busy_nxt   = 1'b1;
                done_nxt   = 1'b1;
                reg_wr_nxt = 1'b1;
            end
            ST_ERR: begin
                busy_nxt  = 1'b1;
                error_nxt = 1'b1;
            end
            default: begin
                smux_nxt = SMUX_REGVAR;
            end
        endcase
    end

    // State register and latched opcode
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            op_q  <= OP_SLL;
        end else begin
            state <= state_nxt;
            op_q  <= op_nxt;
        end
    end

    // Registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            ShifterMux <= SMUX_REGVAR;
            Shift      <= SH_NOP;
            busy       <= 1'b0;
            done       <= 1'b0;
            reg_wr     <= 1'b0;
            error      <= 1'b0;
        end else begin
            ShifterMux <= smux_nxt;
            Shift      <= shift_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            reg_wr     <= reg_wr_nxt;
            error      <= error_nxt;
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: a behavioural RegDesloc/mux model
// produces Saida, a scoreboard of expected completions is filled at issue time
// and drained by a monitor on done/error.
module tb_shift_sequencer;
    import shift_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [1:0] ShifterMux;
    logic [2:0] Shift;
    logic       busy;
    logic       done;
    logic       reg_wr;
    logic       error;

    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [15:0] imm;
    logic [31:0] entrada;
    logic [4:0]  n_amt;
    logic [31:0] saida;

    typedef struct {
        logic        is_err;
        logic [1:0]  sel;
        logic [31:0] result;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int last_done = -100;
    int prev_done = -100;
    int n_legal = 0;

    shift_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .ShifterMux (ShifterMux),
        .Shift      (Shift),
        .busy       (busy),
        .done       (done),
        .reg_wr     (reg_wr),
        .error      (error)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Operand mux model feeding the shift register
    always_comb begin
        entrada = 32'h0;
        n_amt   = 5'd0;
        case (ShifterMux)
            2'b00: begin entrada = a_in;           n_amt = b_in[4:0]; end
            2'b01: begin entrada = b_in;           n_amt = imm[4:0];  end
            2'b10: begin entrada = {16'h0, imm};   n_amt = 5'd16;     end
            default: begin entrada = 32'h0;        n_amt = 5'd0;      end
        endcase
    end

    // RegDesloc model
    always @(posedge clk) begin
        case (Shift)
            SH_LOAD: saida <= entrada;
            SH_LEFT: saida <= saida << n_amt;
            SH_RLOG: saida <= saida >> n_amt;
            SH_RARI: saida <= $signed(saida) >>> n_amt;
            default: saida <= saida;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [1:0] exp_sel(input logic [2:0] o);
        if (o == OP_LUI) return 2'b10;
        if (o <= OP_SRA) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [31:0] exp_res(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] im);
        logic [31:0] r;
        case (o)
            OP_SLL:  r = b << im[4:0];
            OP_SRL:  r = b >> im[4:0];
            OP_SRA:  r = $signed(b) >>> im[4:0];
            OP_SLLV: r = a << b[4:0];
            OP_SRLV: r = a >> b[4:0];
            OP_SRAV: r = $signed(a) >>> b[4:0];
            OP_LUI:  r = {im, 16'h0};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    // Called at a negedge; returns at the negedge of the first cycle after acceptance
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [15:0] im);
        exp_t x;
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        imm   = im;
        x.is_err = (o == OP_ILL);
        x.sel    = exp_sel(o);
        x.result = exp_res(o, a, b, im);
        sb.push_back(x);
        if (o != OP_ILL) n_legal++;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: pop and compare whenever the DUT reports completion or error
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (done === 1'b1) begin
                done_cnt++;
                prev_done = last_done;
                last_done = cyc;
                check("done_reg_wr", 32'(reg_wr), 32'd1);
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_kind", 32'(mon_e.is_err), 32'd0);
                    check("done_smux", 32'(ShifterMux), 32'(mon_e.sel));
                    check("done_shift", 32'(Shift), 32'(SH_NOP));
                    check("saida", saida, mon_e.result);
                end
            end
            if (error === 1'b1) begin
                check("err_reg_wr", 32'(reg_wr), 32'd0);
                check("err_shift", 32'(Shift), 32'(SH_NOP));
                if (sb.size() == 0) begin
                    check("error_unexpected", 32'(error), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("err_kind", 32'(mon_e.is_err), 32'd1);
                end
            end
        end
    end

    initial begin
        int d0;
        logic [2:0]  r_op;
        logic        r_legal;
        int          n_busy;

        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a_in  = 32'h0;
        b_in  = 32'h0;
        imm   = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_smux",   32'(ShifterMux), 32'd0);
        check("rst_shift",  32'(Shift), 32'd0);
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_reg_wr", 32'(reg_wr), 32'd0);
        check("rst_error",  32'(error), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // SLL B=1 shamt=4
        issue(OP_SLL, 32'hDEAD_BEEF, 32'h0000_0001, 16'h0004);
        check("sll_c1_smux", 32'(ShifterMux), 32'd1);
        check("sll_c1_shift", 32'(Shift), 32'(SH_LOAD));
        check("sll_c1_busy", 32'(busy), 32'd1);
        check("sll_c1_done", 32'(done), 32'd0);
        @(negedge clk);
        check("sll_c2_smux", 32'(ShifterMux), 32'd1);
        check("sll_c2_shift", 32'(Shift), 32'(SH_LEFT));
        @(negedge clk);
        check("sll_c3_smux", 32'(ShifterMux), 32'd1);
        check("sll_c3_done", 32'(done), 32'd1);
        check("sll_c3_saida", saida, 32'h0000_0010);
        @(negedge clk);
        check("sll_idle_busy", 32'(busy), 32'd0);

        // SRAV A=0x8000_0000 B=31
        issue(OP_SRAV, 32'h8000_0000, 32'h0000_001F, 16'h0000);
        @(negedge clk);
        check("srav_c2_smux", 32'(ShifterMux), 32'd0);
        check("srav_c2_shift", 32'(Shift), 32'(SH_RARI));
        @(negedge clk);
        check("srav_saida", saida, 32'hFFFF_FFFF);
        @(negedge clk);

        // LUI imm=0x1234
        issue(OP_LUI, 32'h0, 32'h0, 16'h1234);
        @(negedge clk);
        @(negedge clk);
        check("lui_smux", 32'(ShifterMux), 32'd2);
        check("lui_saida", saida, 32'h1234_0000);
        @(negedge clk);

        // Back-to-back: SRL issued during the DONE cycle of an SLL
        d0 = done_cnt;
        issue(OP_SLL, 32'h0, 32'h0000_00F0, 16'h0002);
        @(negedge clk);
        @(negedge clk);
        check("b2b_done1", 32'(done), 32'd1);
        issue(OP_SRL, 32'h0, 32'h8000_0000, 16'h0003);
        check("b2b_load_smux", 32'(ShifterMux), 32'd1);
        check("b2b_load_shift", 32'(Shift), 32'(SH_LOAD));
        check("b2b_load_done", 32'(done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("b2b_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_gap", 32'(last_done - prev_done), 32'd3);

        // Illegal op, with a start attempted in the ERR cycle
        issue(OP_ILL, 32'h0, 32'h0, 16'h0);
        check("ill_error", 32'(error), 32'd1);
        check("ill_reg_wr", 32'(reg_wr), 32'd0);
        check("ill_shift", 32'(Shift), 32'd0);
        check("ill_busy", 32'(busy), 32'd1);
        start = 1'b1;
        op    = OP_SLL;
        @(negedge clk);
        start = 1'b0;
        check("ill_c2_error", 32'(error), 32'd0);
        check("ill_c2_busy", 32'(busy), 32'd0);
        check("ill_c2_shift", 32'(Shift), 32'd0);
        @(negedge clk);
        check("ill_c3_busy", 32'(busy), 32'd0);
        check("ill_c3_shift", 32'(Shift), 32'd0);

        // Start during LOAD ignored; reset in SHIFT aborts
        issue(OP_SRL, 32'h0, 32'h1234_5678, 16'h0005);
        start = 1'b1;
        op    = OP_SLL;
        @(negedge clk);
        start = 1'b0;
        check("abort_c2_shift", 32'(Shift), 32'(SH_RLOG));
        check("abort_c2_smux", 32'(ShifterMux), 32'd1);
        reset = 1'b1;
        sb.delete();
        n_legal--;
        @(negedge clk);
        check("abort_rst_smux",  32'(ShifterMux), 32'd0);
        check("abort_rst_shift", 32'(Shift), 32'd0);
        check("abort_rst_busy",  32'(busy), 32'd0);
        check("abort_rst_done",  32'(done), 32'd0);
        check("abort_rst_regwr", 32'(reg_wr), 32'd0);
        check("abort_rst_error", 32'(error), 32'd0);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (5) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);

        // Randomized traffic with ignored starts and op wiggles while busy
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 7) == 0) r_op = OP_ILL;
            else r_op = 3'($urandom_range(0, 6));
            r_legal = (r_op != OP_ILL);
            issue(r_op, $urandom, $urandom, 16'($urandom));
            n_busy = r_legal ? 2 : 1;
            for (int i = 0; i < n_busy; i++) begin
                if ($urandom_range(0, 2) == 0) start = 1'b1;
                op = 3'($urandom_range(0, 7));
                @(negedge clk);
                start = 1'b0;
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("done_total", 32'(done_cnt), 32'(n_legal));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: sim time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multicycle controller that sequences the shifter datapath: the ShifterMux operand/amount selector feeding the provided RegDesloc shift register. The main control unit issues a one-cycle `start` with a shift opcode. This block then drives the mux select and RegDesloc command through a fixed load → shift → complete sequence, and returns `done` plus a register-bank write strobe. It sits beside the main control FSM and owns the shifter path for SLL/SRL/SRA/SLLV/SRLV/SRAV/LUI.

## Interface
- `SH_NOP`, 3'b000: RegDesloc command, hold.
- `SH_LOAD`, 3'b001: RegDesloc command, load `Entrada`.
- `SH_LEFT`, 3'b010: RegDesloc command, shift left by N.
- `SH_RLOG`, 3'b011: RegDesloc command, logical right by N.
- `SH_RARI`, 3'b100: RegDesloc command, arithmetic right by N.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request pulse, sampled only in IDLE or DONE.
- `op` in 3: 000 SLL, 001 SRL, 010 SRA, 011 SLLV, 100 SRLV, 101 SRAV, 110 LUI, 111 illegal.
- `ShifterMux` out 2: operand/amount select.
  - 00: N=B[4:0], data=A.
  - 01: N=imm[4:0], data=B.
  - 10: N=16, data=zero-extended imm.
  - 11: never driven.
- `Shift` out 3: RegDesloc command.
- `busy` out 1: high in LOAD, SHIFT, DONE, ERR.
- `done` out 1: one-cycle completion pulse.
- `reg_wr` out 1: register-bank write enable, coincident with `done`.
- `error` out 1: one-cycle pulse on illegal `op`.

## Operation
- States: IDLE, LOAD, SHIFT, DONE, ERR.
- IDLE:
  - `start`=1 with legal `op`: latch `op` into `op_q`, go to LOAD.
  - `start`=1 with `op`=111: go to ERR.
  - Otherwise stay in IDLE.
- LOAD: `Shift`=SH_LOAD, `ShifterMux`=sel(`op_q`). Go to SHIFT.
- SHIFT: `Shift`=dir(`op_q`), `ShifterMux` held at sel(`op_q`). Go to DONE.
- DONE: `Shift`=SH_NOP, `done`=1, `reg_wr`=1, `ShifterMux` held.
  - `start`=1 with legal `op`: latch the new `op`, go to LOAD (back-to-back issue).
  - `start`=1 with `op`=111: go to ERR.
  - Otherwise go to IDLE.
- ERR: `error`=1, `Shift`=SH_NOP, `reg_wr`=0. Go to IDLE. `start` is ignored in this state.
- sel mapping:
  - SLLV, SRLV, SRAV → 00.
  - SLL, SRL, SRA → 01.
  - LUI → 10.
- dir mapping:
  - SLL, SLLV, LUI → SH_LEFT.
  - SRL, SRLV → SH_RLOG.
  - SRA, SRAV → SH_RARI.
- Shift amount 0 is not special-cased: the SHIFT cycle still occurs and the result equals the loaded value.
- `start` in LOAD, SHIFT or ERR is ignored. No queuing, no error is raised.
- `op` is read only at acceptance. Changes to `op` mid-sequence have no effect.

## Timing
- All outputs are registered and decoded from state plus `op_q` (Moore). No input reaches an output combinationally.
- Reset (synchronous, takes priority over everything):
  - State becomes IDLE and `op_q` becomes 000.
  - `ShifterMux`=00, `Shift`=SH_NOP.
  - `busy`, `done`, `reg_wr`, `error` = 0.
- Reset asserted mid-sequence aborts the operation: no `done`/`reg_wr` pulse follows.
- Latency, with `start` sampled at edge 0:
  - Cycle 1: LOAD.
  - Cycle 2: SHIFT.
  - Cycle 3: DONE (`done`=`reg_wr`=1).
- RegDesloc result (`Saida`) is valid in the DONE cycle. The register bank captures it at the end of DONE.
- Back-to-back issue: one operation every 3 cycles.
- Illegal op: `error` is high in cycle 1, IDLE again in cycle 2.
- `ShifterMux` is stable from the LOAD cycle through the DONE cycle inclusive.

## Structure
- Shared package `shift_pkg` holds:
  - opcode constants (`OP_SLL`..`OP_LUI`, `OP_ILL`);
  - `SH_*` command constants;
  - `SMUX_REGVAR`=00, `SMUX_SHAMT`=01, `SMUX_LUI`=10;
  - the state enum.
- One natural sub-module: `shift_op_decode`, combinational, `op` → {sel, dir, legal}. It is reused by the main control unit for instruction decode.
- RegDesloc and MUX9eMUX10 are instantiated outside this block.

## Test plan
- SLL, `op`=000, B=0x0000_0001, shamt=4:
  - `ShifterMux`=01 in cycles 1–3.
  - `Shift` = 001, then 010, then 000.
  - `done`=1 in cycle 3, `Saida`=0x0000_0010.
- SRAV, `op`=101, A=0x8000_0000, B=0x0000_001F:
  - `ShifterMux`=00, `Shift`=100 in cycle 2.
  - `Saida`=0xFFFF_FFFF at `done`.
- LUI, `op`=110, imm=0x1234: `ShifterMux`=10, `Saida`=0x1234_0000 at `done`.
- Back-to-back: `start` SRL held in the DONE cycle of a prior SLL. Required response:
  - next cycle is LOAD with `ShifterMux`=01 and `Shift`=001;
  - exactly 2 `done` pulses, 3 cycles apart.
- Illegal `op`=111:
  - `error`=1 for 1 cycle; `reg_wr` and `Shift` stay 0 throughout.
  - `start` asserted in the ERR cycle is ignored.
- `reset` asserted in the SHIFT cycle: next cycle all outputs are 0/00/000, and no `done` pulse follows. `start` during LOAD is ignored.
